// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-requester SPI flash arbiter.
package spi_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_READY,
    ST_SHIFT,
    ST_DESELECT
  } arb_state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine: MSB first, MOSI changes with SCK low, MISO sampled on SCK rise.
module spi_byte_shifter
  import spi_arb_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] tx_byte,
  output logic              done,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              sck,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W = 8;
  localparam int BIT_W = $clog2(BYTE_W);

  logic              busy;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BYTE_W-2:0] tx_sr;
  logic [BYTE_W-1:0] rx_sr;
  logic              half_end;
  logic              rise;
  logic              fall;

  assign half_end = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise     = half_end && !sck;
  assign fall     = half_end && sck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      done    <= 1'b0;
      rx_byte <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy    <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= BIT_W'(BYTE_W - 1);
        sck     <= 1'b0;
        mosi    <= tx_byte[BYTE_W-1];
      end else if (busy) begin
        if (half_end) begin
          div_cnt <= '0;
          sck     <= !sck;
          // The falling edge after bit 0 ends the byte; SCK is left low.
          if (fall) begin
            if (bit_cnt == '0) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              rx_byte <= rx_sr;
            end else begin
              bit_cnt <= bit_cnt - BIT_W'(1);
              mosi    <= tx_sr[BYTE_W-2];
            end
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start && !busy) begin
      tx_sr <= tx_byte[BYTE_W-2:0];
    end else if (fall) begin
      tx_sr <= {tx_sr[BYTE_W-3:0], 1'b0};
    end
    if (rise) begin
      rx_sr <= {rx_sr[BYTE_W-2:0], miso};
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin, transaction-granular sharing of one SPI flash between two requesters.
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 4
) (
  input  logic                      clk_48mhz,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [NUM_REQ*BYTE_W-1:0] tx_data,
  input  logic [NUM_REQ-1:0]        tx_valid,
  output logic [NUM_REQ-1:0]        tx_ready,
  output logic [BYTE_W-1:0]         rx_data,
  output logic [NUM_REQ-1:0]        rx_valid,
  output logic                      spi_cs,
  output logic                      spi_sck,
  output logic                      spi_mosi,
  input  logic                      spi_miso
);

  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_t        state;
  logic              owner;
  logic              last_gnt;
  logic [CNT_W-1:0]  cnt;
  logic              pick;
  logic              arb_slot;
  logic              accept;
  logic              shift_done;
  logic [BYTE_W-1:0] tx_byte;

  always_comb begin
    pick = 1'b0;
    if (req == 2'b11) begin
      pick = !last_gnt;
    end else if (req[1]) begin
      pick = 1'b1;
    end
  end

  // The last DESELECT cycle doubles as an arbitration slot, so a waiting
  // requester sees CS high for exactly CS_IDLE cycles.
  assign arb_slot = (state == ST_IDLE) ||
                    ((state == ST_DESELECT) && (cnt == CNT_W'(CS_IDLE - 1)));
  assign accept   = (state == ST_READY) && tx_valid[owner];
  assign tx_byte  = tx_data[BYTE_W*owner +: BYTE_W];
  assign tx_ready = (state == ST_READY) ? gnt : '0;
  assign rx_valid = shift_done ? gnt : '0;

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      spi_cs   <= 1'b1;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      cnt      <= '0;
    end else if (arb_slot && (|req)) begin
      state    <= ST_SETUP;
      owner    <= pick;
      last_gnt <= pick;
      gnt      <= pick ? 2'b10 : 2'b01;
      spi_cs   <= 1'b0;
      cnt      <= '0;
    end else begin
      unique case (state)
        ST_SETUP: begin
          if (cnt == CNT_W'(CLK_DIV - 1)) begin
            state <= ST_READY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_READY: begin
          if (accept) begin
            state <= ST_SHIFT;
          end else if (!req[owner]) begin
            state  <= ST_DESELECT;
            spi_cs <= 1'b1;
            gnt    <= '0;
            cnt    <= '0;
          end
        end
        ST_SHIFT: begin
          if (shift_done) begin
            state <= ST_READY;
          end
        end
        ST_DESELECT: begin
          if (cnt == CNT_W'(CS_IDLE - 1)) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk_48mhz),
    .reset   (reset),
    .start   (accept),
    .tx_byte (tx_byte),
    .done    (shift_done),
    .rx_byte (rx_data),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .miso    (spi_miso)
  );

endmodule

// File: doc/spi_flash_arbiter.md
# spi_flash_arbiter

Shares the bootloader's single SPI flash port between two requesters, e.g. the USB-to-SPI bridge (requester 0) and the boot/config-readback logic (requester 1). Performs round-robin arbitration at transaction granularity, owns `spi_cs`, and runs one SPI mode-0 byte engine that both requesters drive through a valid/ready byte handshake. Sits between the requesters and the `spi_cs`/`spi_sck`/`spi_mosi`/`spi_miso` pins of `tinyfpga_bootloader`.

## Interface
- `CLK_DIV`, 2: `clk_48mhz` cycles per SCK half-period; legal range 1..255.
- `CS_IDLE`, 4: minimum `clk_48mhz` cycles `spi_cs` stays high between transactions; must be ≥1.

- `clk_48mhz` in 1: sole clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 2: per-requester transaction request. Held high for the whole transaction.
- `gnt` out 2: one-hot or zero. Marks the owner of the transaction.
- `tx_data` in 16: byte for requester i is on bits [8i+7:8i].
- `tx_valid` in 2: per-requester byte offer.
- `tx_ready` out 2: byte accepted when `tx_valid[i] & tx_ready[i]`.
- `rx_data` out 8: byte shifted in from MISO; shared by both requesters.
- `rx_valid` out 2: one-cycle pulse to the owner when `rx_data` is valid.
- `spi_cs` out 1: flash chip select, active low.
- `spi_sck` out 1: SPI clock, idle low.
- `spi_mosi` out 1: serial data to the flash.
- `spi_miso` in 1: serial data from the flash.

## Operation
- Reset values: `gnt`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0.
- Reset state: FSM in IDLE, round-robin pointer favours requester 0.
- **IDLE**
  - If any `req` is high: grant one requester, set `gnt`, drive `spi_cs` low, go to SETUP.
  - Requester choice: the single requester if only one asks. If both ask, the one not granted last; requester 0 first after reset.
- **SETUP**
  - Wait `CLK_DIV` cycles for CS-to-SCK setup, then go to READY.
- **READY**
  - `tx_ready[owner]`=1; all other `tx_ready` bits are always 0.
  - On accept: latch the byte, clear `tx_ready`, go to SHIFT.
  - If `req[owner]` is low and there is no accept: go to DESELECT.
  - If `req[owner]` is low in the same cycle as an accept: the accept wins.
- **SHIFT**
  - 8 bits, MSB first, SPI mode 0.
  - MOSI changes while SCK is low. MISO is sampled on the rising SCK edge.
  - After bit 0: pulse `rx_valid[owner]` with `rx_data` updated, then go to READY.
- **DESELECT**
  - `spi_cs`=1 and `gnt`=0 on entry.
  - Hold for `CS_IDLE` cycles, then go to IDLE.
- Request dropped during SHIFT: the byte always completes. The following READY then takes the DESELECT exit.
- A requester that drops `req` and re-raises it still waits for DESELECT and re-arbitration.
- `req` of the non-owner has no effect until IDLE.
- `tx_valid` without `gnt`: ignored, and the byte is not lost from the requester's side (no accept occurs).
- Reset asserted mid-transaction: outputs take their reset values immediately (asynchronous). The partial byte is discarded and no `rx_valid` is issued.

## Timing
- Grant latency: `req` sampled high in IDLE → `gnt`/`spi_cs` low on the next cycle.
- First `tx_ready`: `CLK_DIV` cycles after `spi_cs` falls.
- Bit 7 timing, for an accept in cycle A:
  - `spi_mosi` carries bit 7 from cycle A+1.
  - First SCK rise at A+1+`CLK_DIV`.
- Each bit is 2·`CLK_DIV` cycles.
- `rx_valid` is high in cycle A+1+16·`CLK_DIV`. `spi_sck` is low in that cycle.
- `tx_ready` returns the cycle after `rx_valid`.
- Back-to-back byte throughput: 16·`CLK_DIV`+2 cycles per byte.
- `rx_data` holds its value until the next `rx_valid`.
- `spi_sck` stays low whenever `spi_cs` is high.

## Structure
- Package `spi_arb_pkg`:
  - state enum: IDLE, SETUP, READY, SHIFT, DESELECT;
  - requester-count constant (2);
  - 8-bit byte width constant.
- Sub-module `spi_byte_shifter`, owning:
  - the `CLK_DIV` half-period counter;
  - the 3-bit bit counter;
  - TX/RX shift registers;
  - a start/done handshake.
- Top level holds:
  - the arbiter, including the last-grant bit;
  - the FSM and the CS idle counter;
  - the handshake muxing.

## Test plan
- **Single byte:** `CLK_DIV`=2, req0 only, send 0x9F; flash model returns 0xA5.
  - `spi_mosi` serialises 1,0,0,1,1,1,1,1.
  - `rx_valid[0]` is high exactly 33 cycles after the accept, with `rx_data`=0xA5.
- **Simultaneous request after reset:** req0 and req1 rise in the same cycle.
  - `gnt`=01 first.
  - After req0 drops: `spi_cs` is high for exactly `CS_IDLE`=4 cycles, then `gnt`=10.
- **Fairness:** both requesters hold `req` continuously for 4 transactions.
  - Grants alternate 0,1,0,1.
  - `spi_cs` rises between each transaction.
- **Drop during SHIFT:** req1 falls during bit 3 of a byte.
  - The byte completes and `rx_valid[1]` pulses.
  - Then `spi_cs` goes high; no further `tx_ready[1]`.
- **Reset mid-byte:** `reset` pulses during bit 5.
  - `spi_cs`=1, `spi_sck`=0, `gnt`=0 within the same cycle.
  - No `rx_valid`.
  - Next req0 restarts from SETUP.
- **Non-owner isolation:** req0 owns the bus; requester 1 drives `tx_valid[1]`=1 with 0x55.
  - `tx_ready[1]` stays 0.
  - MOSI carries only requester 0's bytes.
